// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared tag constants and loader state encoding
package prog_loader_pkg;

    localparam logic [7:0] TAG_TEXT = 8'h00;
    localparam logic [7:0] TAG_DATA = 8'h01;
    localparam logic [7:0] TAG_DONE = 8'hFF;

    typedef enum logic [2:0] {
        TAG    = 3'd0,
        CNT_HI = 3'd1,
        CNT_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_e;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// rtl/prog_loader_word_assembler.sv - big-endian byte-to-word shift register
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    logic [31:0] word_q;
    logic [1:0]  idx_q;

    // The byte being shifted in completes the word when three are already held.
    assign word_done_o = shift_i && (idx_q == 2'd3);
    assign word_o      = word_q;

    // MSB-first shift; clear drops any partial word at the start of a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= 32'h0;
            idx_q  <= 2'd0;
        end else if (clear_i) begin
            word_q <= 32'h0;
            idx_q  <= 2'd0;
        end else if (shift_i) begin
            word_q <= {word_q[23:0], byte_i};
            idx_q  <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot stream parser writing .text/.data words and gating CPU reset
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int TEXT_BASE  = 0,
    parameter int DATA_BASE  = 2048
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  loaded,
    output logic                  error,
    output logic [15:0]           words_written
);

    state_e                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [15:0]           wr_cnt_q, wr_cnt_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  loaded_q, loaded_d;
    logic                  error_q, error_d;

    logic                  accept;
    logic                  frame_start;
    logic                  data_shift;
    logic                  word_done;
    logic [15:0]           cnt_full;

    assign in_ready    = (state_q == TAG) || (state_q == CNT_HI) ||
                         (state_q == CNT_LO) || (state_q == DATA);
    assign accept      = in_valid && in_ready;
    assign frame_start = accept && (state_q == TAG);
    assign data_shift  = accept && (state_q == DATA);
    assign cnt_full    = {cnt_q[15:8], in_data};

    word_assembler u_word_assembler (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (frame_start),
        .shift_i     (data_shift),
        .byte_i      (in_data),
        .word_o      (mem_wdata),
        .word_done_o (word_done)
    );

    // Frame parser: tag, 16-bit count, then words each followed by one write cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        we_d        = 1'b0;
        wr_cnt_d    = wr_cnt_q;
        cpu_reset_d = cpu_reset_q;
        loaded_d    = loaded_q;
        error_d     = error_q;
        case (state_q)
            TAG: begin
                if (accept) begin
                    case (in_data)
                        TAG_TEXT: begin
                            addr_d  = ADDR_WIDTH'(TEXT_BASE);
                            state_d = CNT_HI;
                        end
                        TAG_DATA: begin
                            addr_d  = ADDR_WIDTH'(DATA_BASE);
                            state_d = CNT_HI;
                        end
                        TAG_DONE: begin
                            state_d     = DONE;
                            loaded_d    = 1'b1;
                            cpu_reset_d = 1'b0;
                        end
                        default: begin
                            state_d = ERR;
                            error_d = 1'b1;
                        end
                    endcase
                end
            end
            CNT_HI: begin
                if (accept) begin
                    cnt_d   = {in_data, cnt_q[7:0]};
                    state_d = CNT_LO;
                end
            end
            CNT_LO: begin
                if (accept) begin
                    cnt_d   = cnt_full;
                    state_d = (cnt_full == 16'h0) ? TAG : DATA;
                end
            end
            DATA: begin
                if (word_done) begin
                    we_d    = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                addr_d   = addr_q + ADDR_WIDTH'(1);
                cnt_d    = cnt_q - 16'd1;
                wr_cnt_d = (wr_cnt_q == 16'hFFFF) ? wr_cnt_q : wr_cnt_q + 16'd1;
                state_d  = (cnt_q > 16'd1) ? DATA : TAG;
            end
            DONE: begin
                state_d = DONE;
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = ERR;
                error_d = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset drops any frame in flight and re-holds the CPU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= TAG;
            cnt_q       <= 16'h0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wr_cnt_q    <= 16'h0;
            cpu_reset_q <= 1'b1;
            loaded_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wr_cnt_q    <= wr_cnt_d;
            cpu_reset_q <= cpu_reset_d;
            loaded_q    <= loaded_d;
            error_q     <= error_d;
        end
    end

    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign cpu_reset     = cpu_reset_q;
    assign loaded        = loaded_q;
    assign error         = error_q;
    assign words_written = wr_cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized stream bench for prog_loader against a frame-level model
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        loaded;
    logic        error;
    logic [15:0] words_written;

    int checks = 0;
    int errors = 0;

    logic [7:0]  stream[$];
    logic [43:0] exp_wr[$];
    logic [43:0] obs_wr[$];
    logic        exp_loaded;
    logic        exp_error;
    logic [15:0] exp_words;

    prog_loader #(.ADDR_WIDTH(12), .TEXT_BASE(0), .DATA_BASE(2048)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .cpu_reset     (cpu_reset),
        .loaded        (loaded),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Capture every write strobe; the loader must not accept bytes while writing.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            obs_wr.push_back({mem_addr, mem_wdata});
            check("ready_low_in_write", 64'(in_ready), 64'(0));
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Frame-level parse of the byte stream into the write list it must produce.
    task automatic run_model();
        int i;
        int n;
        int base;
        logic [7:0] tg;
        exp_wr.delete();
        exp_loaded = 1'b0;
        exp_error  = 1'b0;
        exp_words  = 16'h0;
        i = 0;
        while (i < stream.size()) begin
            tg = stream[i];
            i++;
            if (tg == 8'hFF) begin
                exp_loaded = 1'b1;
                break;
            end
            if (tg > 8'h01) begin
                exp_error = 1'b1;
                break;
            end
            base = (tg == 8'h01) ? 2048 : 0;
            n = stream[i] * 256 + stream[i+1];
            i += 2;
            for (int k = 0; k < n; k++) begin
                exp_wr.push_back({12'((base + k) % 4096),
                                  stream[i], stream[i+1], stream[i+2], stream[i+3]});
                i += 4;
                if (exp_words != 16'hFFFF) exp_words++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            repeat ($urandom_range(0, gap)) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("accept_timeout", 64'(0), 64'(1));
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        stream.push_back(w[31:24]);
        stream.push_back(w[23:16]);
        stream.push_back(w[15:8]);
        stream.push_back(w[7:0]);
    endtask

    // Drive the current stream (ending in a done tag) and compare against the model.
    task automatic run_and_check(input string name, input int gap);
        run_model();
        obs_wr.delete();
        for (int i = 0; i < stream.size(); i++) begin
            if (i == stream.size() - 1) begin
                check({name, "_loaded_before_done"}, 64'(loaded), 64'(0));
                check({name, "_cpu_reset_before_done"}, 64'(cpu_reset), 64'(1));
            end
            send_byte(stream[i], gap);
        end
        check({name, "_loaded_at_done_edge"}, 64'(loaded), 64'(exp_loaded));
        check({name, "_cpu_reset_at_done_edge"}, 64'(cpu_reset), 64'(!exp_loaded));
        repeat (3) @(negedge clk);
        check({name, "_write_count"}, 64'(obs_wr.size()), 64'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
            check({name, "_write"}, 64'(obs_wr[i]), 64'(exp_wr[i]));
        check({name, "_words_written"}, 64'(words_written), 64'(exp_words));
        check({name, "_error"}, 64'(error), 64'(exp_error));
        check({name, "_in_ready_done"}, 64'(in_ready), 64'(0));
    endtask

    initial begin
        // Reset values, sampled while reset is still high.
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_cpu_reset", 64'(cpu_reset), 64'(1));
        check("rst_loaded", 64'(loaded), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        check("rst_words", 64'(words_written), 64'(0));
        reset = 1'b0;

        // Two .text words.
        stream = '{8'h00, 8'h00, 8'h02};
        push_word(32'h20080005);
        push_word(32'h2009000A);
        stream.push_back(8'hFF);
        run_and_check("text2", 0);

        // One .data word.
        do_reset();
        stream = '{8'h01, 8'h00, 8'h01};
        push_word(32'hDEADBEEF);
        stream.push_back(8'hFF);
        run_and_check("data1", 0);

        // Empty segment.
        do_reset();
        stream = '{8'h00, 8'h00, 8'h00, 8'hFF};
        run_and_check("empty", 0);

        // Three-word frame with random valid gaps.
        do_reset();
        stream = '{8'h00, 8'h00, 8'h03};
        for (int k = 0; k < 3; k++) push_word($urandom);
        stream.push_back(8'hFF);
        run_and_check("gappy3", 3);

        // Random multi-frame streams, overlapping segments allowed.
        for (int t = 0; t < 8; t++) begin
            int nf;
            do_reset();
            stream.delete();
            nf = $urandom_range(1, 3);
            for (int f = 0; f < nf; f++) begin
                int n;
                n = $urandom_range(0, 4);
                stream.push_back(8'($urandom_range(0, 1)));
                stream.push_back(8'h00);
                stream.push_back(8'(n));
                for (int k = 0; k < n; k++) push_word($urandom);
            end
            stream.push_back(8'hFF);
            run_and_check("random", t % 3);
        end

        // Illegal tag locks up until reset.
        do_reset();
        obs_wr.delete();
        send_byte(8'h42, 0);
        repeat (100) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("err_flag", 64'(error), 64'(1));
        check("err_in_ready", 64'(in_ready), 64'(0));
        check("err_cpu_reset", 64'(cpu_reset), 64'(1));
        check("err_loaded", 64'(loaded), 64'(0));
        check("err_no_writes", 64'(obs_wr.size()), 64'(0));
        do_reset();
        check("err_cleared", 64'(error), 64'(0));
        check("err_ready_after_reset", 64'(in_ready), 64'(1));

        // Reset in the middle of a word, then a clean one-word frame.
        do_reset();
        obs_wr.delete();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_cpu_reset", 64'(cpu_reset), 64'(1));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("midrst_no_writes", 64'(obs_wr.size()), 64'(0));
        stream = '{8'h00, 8'h00, 8'h01};
        push_word(32'hA5C30F96);
        stream.push_back(8'hFF);
        run_and_check("midrst", 0);

        // .data segment long enough to wrap past the top of memory.
        do_reset();
        stream = '{8'h01, 8'h08, 8'h01};
        for (int k = 0; k < 2049; k++) push_word($urandom);
        stream.push_back(8'hFF);
        run_and_check("wrap", 0);
        if (obs_wr.size() > 0)
            check("wrap_last_addr", 64'(obs_wr[obs_wr.size()-1][43:32]), 64'(0));
        else
            check("wrap_last_addr_present", 64'(0), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
